// File: rtl/instruction_cache.sv
// ---------------------------------------------------------------------------
// instruction_cache
//
// Direct-mapped, read-only instruction cache sitting between the fetch stage
// and InstructionMemory. Each line holds 128 bits (four 32-bit instructions).
// A hit is answered combinationally in the same cycle. A miss stalls fetch,
// drives the line address to InstructionMemory, waits MEM_WAIT clock edges
// and then captures the whole line.
//
// Parameters
//   NUM_LINES  number of cache lines (power of two, >= 2)
//   MEM_WAIT   edges from driving memoryAddress to capturing memoryData (>= 1)
//
// Ports
//   clock          rising-edge clock
//   reset          synchronous, active-high
//   cpuAddress     fetch byte address
//   cpuRead        fetch request valid
//   instruction    fetched word, zero unless hit
//   hit            request served this cycle
//   stall          fetch must hold cpuAddress and retry
//   memoryAddress  registered line address to InstructionMemory (low 4 bits 0)
//   memoryData     128-bit line from InstructionMemory, byte 0 at [7:0]
// ---------------------------------------------------------------------------
module instruction_cache #(
    parameter int NUM_LINES = 16,
    parameter int MEM_WAIT  = 5
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [31:0]  cpuAddress,
    input  logic         cpuRead,
    output logic [31:0]  instruction,
    output logic         hit,
    output logic         stall,
    output logic [31:0]  memoryAddress,
    input  logic [127:0] memoryData
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 32 - 4 - IDX_W;
    localparam int CNT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_WAIT - 1);

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   waitCount;
    logic [TAG_W-1:0]   missTag;
    logic [IDX_W-1:0]   missIndex;

    logic [NUM_LINES-1:0] validBits;
    logic [TAG_W-1:0]     tagMem  [NUM_LINES];
    logic [127:0]         dataMem [NUM_LINES];

    logic [1:0]         wordSel;
    logic [IDX_W-1:0]   cpuIndex;
    logic [TAG_W-1:0]   cpuTag;
    logic [127:0]       lineData;
    logic [31:0]        selectedWord;
    logic               lookupHit;
    logic               fillDone;
    logic               unusedByteOffset;

    // Address split: byte offset is irrelevant for word fetches.
    assign wordSel          = cpuAddress[3:2];
    assign cpuIndex         = cpuAddress[IDX_W+3:4];
    assign cpuTag           = cpuAddress[31:IDX_W+4];
    assign unusedByteOffset = ^cpuAddress[1:0];

    // Tag lookup and word extraction for the addressed line.
    assign lineData     = dataMem[cpuIndex];
    assign selectedWord = lineData[{wordSel, 5'b00000} +: 32];
    assign lookupHit    = validBits[cpuIndex] && (tagMem[cpuIndex] == cpuTag);

    // The fill finishes on the edge where the wait counter reaches its last value.
    assign fillDone = (state == FILL) && (waitCount == LAST_WAIT);

    // Outputs are forced quiet while reset is held, including mid-fill.
    always_comb begin
        hit         = 1'b0;
        stall       = 1'b0;
        instruction = 32'h0;
        if (!reset) begin
            if (state == IDLE) begin
                hit   = cpuRead && lookupHit;
                stall = cpuRead && !lookupHit;
            end else begin
                stall = 1'b1;
            end
            if (hit) begin
                instruction = selectedWord;
            end
        end
    end

    // Control FSM: IDLE serves hits and launches a fill on a miss; FILL
    // counts memory latency and then validates the latched line. The miss
    // tag/index are latched so address changes during FILL cannot redirect it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            validBits     <= '0;
            waitCount     <= '0;
            memoryAddress <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpuRead && !lookupHit) begin
                        missTag       <= cpuTag;
                        missIndex     <= cpuIndex;
                        memoryAddress <= {cpuTag, cpuIndex, 4'b0000};
                        waitCount     <= '0;
                        state         <= FILL;
                    end
                end
                FILL: begin
                    waitCount <= waitCount + 1'b1;
                    if (waitCount == LAST_WAIT) begin
                        validBits[missIndex] <= 1'b1;
                        state                <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data arrays carry no reset; the valid bits guard them. A fill
    // overwrites the indexed line whatever it held before.
    always_ff @(posedge clock) begin
        if (!reset && fillDone) begin
            tagMem[missIndex]  <= missTag;
            dataMem[missIndex] <= memoryData;
        end
    end

endmodule
